// File: rtl/ttc_intr_sched29_pkg.sv
// Shared types and defaults for the timer interrupt scheduler.
// State enum, default sizes and the timer-index width helper.
package ttc_sched_pkg29;

  localparam int DEF_NUM_TMR = 3;
  localparam int DEF_SRC_W   = 6;
  localparam int DEF_HOLDOFF = 2;
  localparam int DEF_TMO_CYC = 255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    PRESENT = 3'd2,
    CLEAR   = 3'd3,
    HOLD    = 3'd4
  } sched_state_t;

  // Width of a timer index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ttc_intr_sched29_if.sv
// CPU-side interrupt presentation interface of the timer interrupt scheduler.
// master = scheduler, slave = interrupt consumer.
interface ttc_intr_sched29_if #(
  parameter int NUM_TMR = ttc_sched_pkg29::DEF_NUM_TMR,
  parameter int SRC_W   = ttc_sched_pkg29::DEF_SRC_W
);
  localparam int IDX_W = ttc_sched_pkg29::idx_w(NUM_TMR);

  // Handshake: irq_valid rises with irq_tmr_id/irq_src and holds them stable
  // until the consumer raises irq_ack; a transfer completes on the first clock
  // edge with irq_valid & irq_ack. irq_ack while irq_valid=0 has no effect.
  logic             irq_valid;
  logic [IDX_W-1:0] irq_tmr_id;
  logic [SRC_W-1:0] irq_src;
  logic             irq_ack;

  modport master (output irq_valid, output irq_tmr_id, output irq_src, input irq_ack);
  modport slave  (input irq_valid, input irq_tmr_id, input irq_src, output irq_ack);

endinterface

// File: rtl/ttc_rr_arb29.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping to timer 0.
module ttc_rr_arb29
  import ttc_sched_pkg29::*;
#(
  parameter int NUM_TMR = DEF_NUM_TMR,
  localparam int IDX_W  = idx_w(NUM_TMR)
) (
  input  logic [NUM_TMR-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the candidate nearest rr_ptr overwrites the others.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = NUM_TMR - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_TMR);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/ttc_intr_sched29.sv
// Round-robin interrupt scheduler for the triple timer counter.
// Optional ack timeout with tmo_flag output: define TTC_SCHED_TIMEOUT_EN.
module ttc_intr_sched29
  import ttc_sched_pkg29::*;
#(
  parameter int NUM_TMR = DEF_NUM_TMR,
  parameter int SRC_W   = DEF_SRC_W,
  parameter int HOLDOFF = DEF_HOLDOFF
`ifdef TTC_SCHED_TIMEOUT_EN
  , parameter int TMO_CYC = DEF_TMO_CYC
`endif
) (
  input  logic                          pclk29,
  input  logic                          p_reset29,
  input  logic                          sched_en,
  input  logic [NUM_TMR-1:0]            tmr_intr,
  input  logic [NUM_TMR*SRC_W-1:0]      tmr_intr_reg,
  ttc_intr_sched29_if.master            irq,
  output logic [NUM_TMR-1:0]            clear_interrupt,
  output logic                          busy,
`ifdef TTC_SCHED_TIMEOUT_EN
  output logic                          tmo_flag,
`endif
  output sched_state_t                  state_dbg,
  output logic [idx_w(NUM_TMR)-1:0]     rr_ptr_dbg
);

  localparam int IDX_W = idx_w(NUM_TMR);

  sched_state_t     state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [2:0]       hold_cnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_id;
  logic [SRC_W-1:0] reg_arr [NUM_TMR];
`ifdef TTC_SCHED_TIMEOUT_EN
  logic [7:0]       tmo_cnt;
`endif

  for (genvar i = 0; i < NUM_TMR; i++) begin : g_unpack
    assign reg_arr[i] = tmr_intr_reg[i*SRC_W +: SRC_W];
  end

  ttc_rr_arb29 #(.NUM_TMR(NUM_TMR)) u_arb (
    .req       (tmr_intr),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Pointer moves past the serviced (or stalled) timer.
  assign next_ptr = (irq.irq_tmr_id == IDX_W'(NUM_TMR - 1)) ? '0 : irq.irq_tmr_id + 1'b1;

  always_ff @(posedge pclk29) begin
    if (p_reset29) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      hold_cnt        <= '0;
      irq.irq_valid   <= 1'b0;
      irq.irq_tmr_id  <= '0;
      irq.irq_src     <= '0;
      clear_interrupt <= '0;
`ifdef TTC_SCHED_TIMEOUT_EN
      tmo_cnt         <= '0;
      tmo_flag        <= 1'b0;
`endif
    end else begin
      clear_interrupt <= '0;
`ifdef TTC_SCHED_TIMEOUT_EN
      tmo_flag        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sched_en && (|tmr_intr)) state <= ARB;
        end
        ARB: begin
          if (gnt_valid) begin
            state          <= PRESENT;
            irq.irq_valid  <= 1'b1;
            irq.irq_tmr_id <= gnt_id;
            irq.irq_src    <= reg_arr[gnt_id];
`ifdef TTC_SCHED_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        PRESENT: begin
          if (irq.irq_ack) begin
            state           <= CLEAR;
            irq.irq_valid   <= 1'b0;
            clear_interrupt <= NUM_TMR'(1) << irq.irq_tmr_id;
          end
`ifdef TTC_SCHED_TIMEOUT_EN
          // Stalled consumer: skip the clear and move on to the next timer.
          else if (tmo_cnt == 8'(TMO_CYC - 1)) begin
            state         <= HOLD;
            irq.irq_valid <= 1'b0;
            rr_ptr        <= next_ptr;
            hold_cnt      <= 3'(HOLDOFF);
            tmo_flag      <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        CLEAR: begin
          rr_ptr   <= next_ptr;
          hold_cnt <= 3'(HOLDOFF);
          state    <= HOLD;
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt <= 3'd1) state <= (sched_en && (|tmr_intr)) ? ARB : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_ttc_intr_sched29.sv
// Self-checking bench for ttc_intr_sched29: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_ttc_intr_sched29;
  import ttc_sched_pkg29::*;

  localparam int NUM_TMR = 3;
  localparam int SRC_W   = 6;
  localparam int HOLDOFF = 2;
  localparam int IDX_W   = idx_w(NUM_TMR);
`ifdef TTC_SCHED_TIMEOUT_EN
  localparam int TMO_CYC = 10;
`endif

  logic                     pclk29 = 1'b0;
  logic                     p_reset29 = 1'b1;
  logic                     sched_en = 1'b0;
  logic [NUM_TMR-1:0]       tmr_intr = '0;
  logic [NUM_TMR*SRC_W-1:0] tmr_intr_reg = '0;
  logic [NUM_TMR-1:0]       clear_interrupt;
  logic                     busy;
  sched_state_t             state_dbg;
  logic [IDX_W-1:0]         rr_ptr_dbg;
`ifdef TTC_SCHED_TIMEOUT_EN
  logic                     tmo_flag;
`endif

  ttc_intr_sched29_if #(.NUM_TMR(NUM_TMR), .SRC_W(SRC_W)) irq ();

  ttc_intr_sched29 #(
    .NUM_TMR(NUM_TMR), .SRC_W(SRC_W), .HOLDOFF(HOLDOFF)
`ifdef TTC_SCHED_TIMEOUT_EN
    , .TMO_CYC(TMO_CYC)
`endif
  ) dut (
    .pclk29          (pclk29),
    .p_reset29       (p_reset29),
    .sched_en        (sched_en),
    .tmr_intr        (tmr_intr),
    .tmr_intr_reg    (tmr_intr_reg),
    .irq             (irq.master),
    .clear_interrupt (clear_interrupt),
    .busy            (busy),
`ifdef TTC_SCHED_TIMEOUT_EN
    .tmo_flag        (tmo_flag),
`endif
    .state_dbg       (state_dbg),
    .rr_ptr_dbg      (rr_ptr_dbg)
  );

  // Clock / reset
  always #5 pclk29 = ~pclk29;
  initial irq.irq_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_ptr = 0;
  logic [NUM_TMR-1:0]       edge_intr;
  logic [NUM_TMR*SRC_W-1:0] edge_reg;
  logic [IDX_W-1:0]         exp_q[$];

  // Driver tasks: remember what the coming edge sees, then step past it.
  task automatic tick();
    edge_intr = tmr_intr;
    edge_reg  = tmr_intr_reg;
    @(posedge pclk29);
    #1;
    cyc++;
  endtask

  task automatic set_reg(input int i, input logic [SRC_W-1:0] v);
    tmr_intr_reg[i*SRC_W +: SRC_W] = v;
  endtask

  task automatic drain();
    repeat (HOLDOFF + 3) tick();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!irq.irq_valid && n < budget) begin
      tick();
      n++;
    end
    ok = irq.irq_valid;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid: irq_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  // Reference arbitration: list timers in round-robin order from ptr, take
  // the first requester.
  function automatic int model_pick(input logic [NUM_TMR-1:0] req, input int ptr);
    int order[$];
    for (int i = ptr; i < NUM_TMR; i++) order.push_back(i);
    for (int i = 0; i < ptr; i++) order.push_back(i);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic test_reset();
    p_reset29 = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({irq.irq_valid, irq.irq_tmr_id, irq.irq_src, clear_interrupt, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%0d id=%0d src=%0h clr=%b busy=%0d, required all 0",
               irq.irq_valid, irq.irq_tmr_id, irq.irq_src, clear_interrupt, busy);
    end
    n_cmp++;
    if (state_dbg !== IDLE || rr_ptr_dbg !== '0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d rr_ptr=%0d, required 0 0", state_dbg, rr_ptr_dbg);
    end
    p_reset29 = 1'b0;
    sched_en  = 1'b1;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    int t0; bit ok;
    set_reg(1, 6'h04);
    tmr_intr = 3'b010;
    t0 = cyc;
    wait_valid(10, ok);
    if (!ok) return;
    n_cmp++;
    if (cyc - t0 != 2) begin
      n_bad++; $display("FAIL single_latency: got %0d cycles, required 2", cyc - t0);
    end
    n_cmp++;
    if (irq.irq_tmr_id !== 2'd1 || irq.irq_src !== 6'h04) begin
      n_bad++; $display("FAIL single_grant: id=%0d src=%0h, required 1 04", irq.irq_tmr_id, irq.irq_src);
    end
    repeat (2) begin
      tick();
      n_cmp++;
      if (irq.irq_valid !== 1'b1 || clear_interrupt !== '0) begin
        n_bad++; $display("FAIL single_hold: valid=%0d clr=%b, required 1 000", irq.irq_valid, clear_interrupt);
      end
    end
    irq.irq_ack = 1'b1;
    tick();
    n_cmp++;
    if (clear_interrupt !== 3'b010 || irq.irq_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_clear: clr=%b valid=%0d, required 010 0", clear_interrupt, irq.irq_valid);
    end
    irq.irq_ack = 1'b0;
    tmr_intr = '0;
    set_reg(1, '0);
    model_ptr = 2;
    tick();
    n_cmp++;
    if (clear_interrupt !== '0) begin
      n_bad++; $display("FAIL single_pulse_width: clr=%b, required 000", clear_interrupt);
    end
    drain();
    n_cmp++;
    if (busy !== 1'b0 || rr_ptr_dbg !== IDX_W'(model_ptr)) begin
      n_bad++; $display("FAIL single_idle: busy=%0d rr_ptr=%0d, required 0 %0d", busy, rr_ptr_dbg, model_ptr);
    end
  endtask

  task automatic test_wrap();
    bit ok; int exp_id;
    tmr_intr = 3'b011;
    wait_valid(10, ok);
    if (!ok) return;
    exp_id = model_pick(edge_intr, model_ptr);
    n_cmp++;
    if (int'(irq.irq_tmr_id) != exp_id || exp_id != 0) begin
      n_bad++; $display("FAIL wrap_grant: id=%0d, required 0 (model %0d)", irq.irq_tmr_id, exp_id);
    end
    irq.irq_ack = 1'b1;
    tick();
    n_cmp++;
    if (clear_interrupt !== 3'b001) begin
      n_bad++; $display("FAIL wrap_clear: clr=%b, required 001", clear_interrupt);
    end
    irq.irq_ack = 1'b0;
    tmr_intr = '0;
    model_ptr = 1;
    drain();
  endtask

  task automatic test_round_robin();
    bit ok; int last_rise; logic [IDX_W-1:0] exp_id;
    p_reset29 = 1'b1; tick(); p_reset29 = 1'b0;
    model_ptr = 0;
    for (int k = 0; k < 6; k++) exp_q.push_back(IDX_W'(k % NUM_TMR));
    tmr_intr = 3'b111;
    last_rise = 0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(HOLDOFF + 8, ok);
      if (!ok) return;
      exp_id = exp_q.pop_front();
      n_cmp++;
      if (irq.irq_tmr_id !== exp_id) begin
        n_bad++; $display("FAIL rr_order[%0d]: id=%0d, required %0d", k, irq.irq_tmr_id, exp_id);
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - last_rise != HOLDOFF + 4) begin
          n_bad++; $display("FAIL rr_spacing[%0d]: got %0d, required %0d", k, cyc - last_rise, HOLDOFF + 4);
        end
      end
      last_rise = cyc;
      tick();
      irq.irq_ack = 1'b1;
      tick();
      irq.irq_ack = 1'b0;
      n_cmp++;
      if (clear_interrupt !== (NUM_TMR'(1) << exp_id)) begin
        n_bad++; $display("FAIL rr_clear[%0d]: clr=%b, required one-hot %0d", k, clear_interrupt, exp_id);
      end
      model_ptr = (int'(exp_id) + 1) % NUM_TMR;
    end
    tmr_intr = '0;
    drain();
  endtask

  task automatic test_stable();
    bit ok;
    set_reg(2, 6'h01);
    tmr_intr = 3'b100;
    wait_valid(10, ok);
    if (!ok) return;
    n_cmp++;
    if (irq.irq_tmr_id !== 2'd2 || irq.irq_src !== 6'h01) begin
      n_bad++; $display("FAIL stable_grant: id=%0d src=%0h, required 2 01", irq.irq_tmr_id, irq.irq_src);
    end
    set_reg(2, 6'h03);
    tmr_intr = '0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (irq.irq_valid !== 1'b1 || irq.irq_src !== 6'h01 || irq.irq_tmr_id !== 2'd2) begin
        n_bad++; $display("FAIL stable_hold: valid=%0d id=%0d src=%0h, required 1 2 01",
                          irq.irq_valid, irq.irq_tmr_id, irq.irq_src);
      end
    end
    irq.irq_ack = 1'b1;
    tick();
    irq.irq_ack = 1'b0;
    n_cmp++;
    if (clear_interrupt !== 3'b100) begin
      n_bad++; $display("FAIL stable_clear: clr=%b, required 100", clear_interrupt);
    end
    set_reg(2, '0);
    model_ptr = 0;
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    tmr_intr = 3'b011;
    wait_valid(10, ok);
    if (!ok) return;
    irq.irq_ack = 1'b1;
    tick();
    irq.irq_ack = 1'b0;
    tmr_intr = 3'b010;
    model_ptr = 1;
    wait_valid(HOLDOFF + 6, ok);
    if (!ok) return;
    n_cmp++;
    if (int'(irq.irq_tmr_id) != model_pick(edge_intr, model_ptr)) begin
      n_bad++; $display("FAIL rst_mid_grant: id=%0d, required %0d", irq.irq_tmr_id, model_pick(edge_intr, model_ptr));
    end
    p_reset29 = 1'b1;
    tick();
    n_cmp++;
    if ({irq.irq_valid, irq.irq_tmr_id, irq.irq_src, clear_interrupt, busy, rr_ptr_dbg} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: valid=%0d id=%0d src=%0h clr=%b busy=%0d rr_ptr=%0d, required all 0",
                        irq.irq_valid, irq.irq_tmr_id, irq.irq_src, clear_interrupt, busy, rr_ptr_dbg);
    end
    p_reset29 = 1'b0;
    tmr_intr = '0;
    model_ptr = 0;
    tick();
    n_cmp++;
    if (clear_interrupt !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_noclear: clr=%b busy=%0d, required 000 0", clear_interrupt, busy);
    end
  endtask

  task automatic test_sched_en();
    bit ok; int t0;
    sched_en = 1'b0;
    tmr_intr = 3'b001;
    irq.irq_ack = 1'b1;
    repeat (5) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || irq.irq_valid !== 1'b0 || clear_interrupt !== '0) begin
        n_bad++; $display("FAIL en_off_idle: busy=%0d valid=%0d clr=%b, required 0 0 000", busy, irq.irq_valid, clear_interrupt);
      end
    end
    irq.irq_ack = 1'b0;
    sched_en = 1'b1;
    t0 = cyc;
    wait_valid(10, ok);
    if (!ok) return;
    n_cmp++;
    if (cyc - t0 != 2 || irq.irq_tmr_id !== 2'd0) begin
      n_bad++; $display("FAIL en_on_grant: latency=%0d id=%0d, required 2 0", cyc - t0, irq.irq_tmr_id);
    end
    sched_en = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (irq.irq_valid !== 1'b1) begin
      n_bad++; $display("FAIL en_off_present: valid=%0d, required 1", irq.irq_valid);
    end
    irq.irq_ack = 1'b1;
    tick();
    irq.irq_ack = 1'b0;
    n_cmp++;
    if (clear_interrupt !== 3'b001) begin
      n_bad++; $display("FAIL en_off_clear: clr=%b, required 001", clear_interrupt);
    end
    model_ptr = 1;
    repeat (HOLDOFF + 3) tick();
    n_cmp++;
    if (busy !== 1'b0 || irq.irq_valid !== 1'b0) begin
      n_bad++; $display("FAIL en_off_hold_exit: busy=%0d valid=%0d, required 0 0", busy, irq.irq_valid);
    end
    tmr_intr = '0;
    sched_en = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit ok; bit have_clr; int clr_cyc; int exp_id; int d;
    logic [SRC_W-1:0] exp_src;
    have_clr = 1'b0;
    clr_cyc  = 0;
    tmr_intr_reg = (NUM_TMR*SRC_W)'({$urandom, $urandom});
    tmr_intr = NUM_TMR'($urandom_range(1, (1 << NUM_TMR) - 1));
    for (int t = 0; t < 25; t++) begin
      wait_valid(HOLDOFF + 8, ok);
      if (!ok) return;
      if (have_clr) begin
        n_cmp++;
        if (cyc - clr_cyc != HOLDOFF + 2) begin
          n_bad++; $display("FAIL rand_gap[%0d]: got %0d, required %0d", t, cyc - clr_cyc, HOLDOFF + 2);
        end
      end
      exp_id  = model_pick(edge_intr, model_ptr);
      exp_src = edge_reg[exp_id*SRC_W +: SRC_W];
      n_cmp++;
      if (int'(irq.irq_tmr_id) != exp_id || irq.irq_src !== exp_src) begin
        n_bad++; $display("FAIL rand_grant[%0d]: id=%0d src=%0h, required %0d %0h",
                          t, irq.irq_tmr_id, irq.irq_src, exp_id, exp_src);
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        tmr_intr = NUM_TMR'($urandom);
        tmr_intr_reg = (NUM_TMR*SRC_W)'({$urandom, $urandom});
        tick();
        n_cmp++;
        if (irq.irq_valid !== 1'b1 || int'(irq.irq_tmr_id) != exp_id || irq.irq_src !== exp_src || clear_interrupt !== '0) begin
          n_bad++; $display("FAIL rand_stable[%0d]: valid=%0d id=%0d src=%0h clr=%b", t,
                            irq.irq_valid, irq.irq_tmr_id, irq.irq_src, clear_interrupt);
        end
      end
      irq.irq_ack = 1'b1;
      tick();
      irq.irq_ack = 1'b0;
      n_cmp++;
      if (clear_interrupt !== (NUM_TMR'(1) << exp_id) || irq.irq_valid !== 1'b0) begin
        n_bad++; $display("FAIL rand_clear[%0d]: clr=%b valid=%0d, required one-hot %0d", t,
                          clear_interrupt, irq.irq_valid, exp_id);
      end
      have_clr  = 1'b1;
      clr_cyc   = cyc;
      model_ptr = (exp_id + 1) % NUM_TMR;
      tmr_intr[exp_id] = 1'b0;
      set_reg(exp_id, '0);
      tmr_intr = tmr_intr | NUM_TMR'($urandom);
      if (tmr_intr == '0) tmr_intr[$urandom_range(0, NUM_TMR - 1)] = 1'b1;
    end
    tmr_intr = '0;
    drain();
  endtask

`ifdef TTC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int n;
    p_reset29 = 1'b1; tick(); p_reset29 = 1'b0;
    model_ptr = 0;
    tmr_intr = 3'b011;
    wait_valid(10, ok);
    if (!ok) return;
    n = 0;
    while (!tmo_flag && n < TMO_CYC + 10) begin
      tick();
      n++;
      if (clear_interrupt !== '0) begin
        n_cmp++; n_bad++;
        $display("FAIL tmo_noclear: clr=%b, required 000", clear_interrupt);
      end
    end
    n_cmp++;
    if (n != TMO_CYC || irq.irq_valid !== 1'b0) begin
      n_bad++; $display("FAIL tmo_latency: flag after %0d valid=%0d, required %0d 0", n, irq.irq_valid, TMO_CYC);
    end
    model_ptr = 1;
    wait_valid(HOLDOFF + 6, ok);
    if (!ok) return;
    n_cmp++;
    if (int'(irq.irq_tmr_id) != model_pick(edge_intr, model_ptr)) begin
      n_bad++; $display("FAIL tmo_next: id=%0d, required %0d", irq.irq_tmr_id, model_pick(edge_intr, model_ptr));
    end
    irq.irq_ack = 1'b1;
    tick();
    irq.irq_ack = 1'b0;
    tmr_intr = '0;
    drain();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Final report
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_stable();
    test_reset_mid();
    test_sched_en();
    test_random();
`ifdef TTC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
